// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: word-indexed PC, one registered
// instruction per cycle to decode, taken-branch redirect, sticky out-of-range halt.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | fetching; honours branch, stall and out-of-range in that order
// HALT  | fetch ran past the end of instruction memory; frozen until reset
module pc_fetch_unit #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        halted
);

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            instr_q       <= NOP;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        unique case (state_q)
            HALT: begin
                instr_valid_d = 1'b0;
            end
            RUN: begin
                // A branch only counts when it belongs to a real instruction.
                if (branch_taken && instr_valid_q) begin
                    pc_d          = instr_pc_q + branch_offset;
                    instr_d       = NOP;
                    instr_valid_d = 1'b0;
                end else if (stall) begin
                    pc_d          = pc_q;
                end else if (pc_q >= LIMIT) begin
                    state_d       = HALT;
                    instr_d       = NOP;
                    instr_valid_d = 1'b0;
                end else begin
                    instr_d       = imem_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 32'd1;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes expected post-edge state
// from a rule-level reference model; a monitor pops and compares after each edge.
module tb_pc_fetch_unit;

    localparam int          WORDS = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;

    logic [31:0] mem [WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_halt;

    pc_fetch_unit #(.IMEM_WORDS(WORDS), .RESET_PC(32'd0)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    assign imem_data = (imem_addr < WORDS) ? mem[imem_addr[5:0]] : 32'hDEAD_BEEF;

    always #5 clock = ~clock;

    function void model_reset();
        m_pc    = 32'd0;
        m_instr = NOP;
        m_ipc   = 32'd0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
    endfunction

    function void model_step(input logic br, input logic [31:0] off, input logic st);
        if (m_halt) begin
            m_valid = 1'b0;
        end else if (br && m_valid) begin
            m_pc    = m_ipc + off;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (st) begin
            m_valid = m_valid;
        end else if (m_pc >= WORDS) begin
            m_halt  = 1'b1;
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc[5:0]];
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd1;
        end
    endfunction

    function void compare(input string name, input exp_t e);
        n_checks++;
        if (imem_addr === e.pc && instr === e.instr && instr_pc === e.ipc &&
            instr_valid === e.valid && halted === e.halt) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h instr=%h ipc=%h valid=%b halted=%b, want pc=%h instr=%h ipc=%h valid=%b halted=%b",
                     name, imem_addr, instr, instr_pc, instr_valid, halted,
                     e.pc, e.instr, e.ipc, e.valid, e.halt);
        end
    endfunction

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) compare("cycle", exp_q.pop_front());
    end

    // Called positioned at a falling edge; returns at the next falling edge.
    task automatic step(input logic br, input logic [31:0] off, input logic st);
        branch_taken  = br;
        branch_offset = off;
        stall         = st;
        model_step(br, off, st);
        exp_q.push_back('{m_pc, m_instr, m_ipc, m_valid, m_halt});
        @(negedge clock);
    endtask

    task automatic check_reset_values(input string name);
        exp_t e;
        e = '{32'd0, NOP, 32'd0, 1'b0, 1'b0};
        compare(name, e);
    endtask

    // Assert reset between edges, check immediately, release at a falling edge.
    task automatic async_reset(input logic scramble);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        if (scramble) begin
            for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_to_ipc(input logic [31:0] target);
        for (int n = 0; n < 200; n++) begin
            if (m_valid && m_ipc == target) return;
            step(1'b0, 32'd0, 1'b0);
        end
        n_checks++;
        $display("FAIL run_to_ipc: never reached ipc=%0d (model ipc=%0d)", target, m_ipc);
    endtask

    initial begin
        int r;
        logic [31:0] off;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h100 + i;
        model_reset();

        repeat (2) @(negedge clock);
        check_reset_values("reset_hold");
        reset = 1'b0;

        // Sequential fetch from RESET_PC
        repeat (3) step(1'b0, 32'd0, 1'b0);
        run_to_ipc(32'd3);
        // Forward branch, then a branch request during the bubble is ignored
        step(1'b1, 32'd5, 1'b0);
        step(1'b1, 32'd7, 1'b0);
        run_to_ipc(32'd10);
        // Backward branch wins over stall, then a 3-edge stall
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        repeat (3) step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        // End of memory and sticky halt
        run_to_ipc(32'd63);
        step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'hFFFF_FFF0, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        async_reset(1'b0);

        // Wrap to 0xFFFFFFFF, then halt
        run_to_ipc(32'd1);
        step(1'b1, 32'hFFFF_FFFE, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        async_reset(1'b1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 3 || (m_halt && r < 30)) begin
                async_reset(1'b1);
            end else begin
                if ($urandom_range(0, 15) == 0) off = $urandom;
                else off = 32'($signed($urandom_range(0, 40)) - 20);
                step($urandom_range(0, 3) == 0, off, $urandom_range(0, 3) == 0);
            end
        end

        @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
